// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: read-owner encoding,
// default data width and the memory-mapped I/O addresses of the processor.
package dmem_arbiter_pkg;

    localparam int DBITS_DEF = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_AUX  = 2'd2;

    localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the CPU load/store path (fixed
// priority) and an auxiliary requester. A starvation counter forces an aux
// grant after STARVE_LIMIT denied cycles. Read data is steered back to the
// port that issued the read, one cycle after the grant. The processor top
// level drives its PC write enable from ~cpu_stall.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DBITS        = DBITS_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [DBITS-1:0] cpu_addr,
    input  logic [DBITS-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [DBITS-1:0] cpu_rdata,

    input  logic             aux_req,
    input  logic             aux_we,
    input  logic [DBITS-1:0] aux_addr,
    input  logic [DBITS-1:0] aux_wdata,
    output logic             aux_gnt,
    output logic             aux_rvalid,
    output logic [DBITS-1:0] aux_rdata,

    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic [1:0] rd_owner_p1;
    logic       aux_win;
    logic       cpu_win;

    // Counter steps up by one but never passes the starvation limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= LIMIT) ? LIMIT : v + 4'd1;
    endfunction

    // Issue stage: combinational grant; no grant at all while reset is high.
    assign aux_win   = ~reset & aux_req & (~cpu_req | (starve_cnt == LIMIT));
    assign cpu_win   = ~reset & cpu_req & ~aux_win;

    assign aux_gnt   = aux_win;
    assign cpu_gnt   = cpu_win;
    assign cpu_stall = cpu_req & ~cpu_win;

    // With no grant the CPU port is presented, but the write strobe stays low.
    assign mem_addr  = aux_win ? aux_addr  : cpu_addr;
    assign mem_wdata = aux_win ? aux_wdata : cpu_wdata;
    assign mem_we    = aux_win ? aux_we    : (cpu_win & cpu_we);

    // Return stage: rvalid is masked during reset so an in-flight read is dropped.
    assign cpu_rvalid = ~reset & (rd_owner_p1 == OWN_CPU);
    assign aux_rvalid = ~reset & (rd_owner_p1 == OWN_AUX);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign aux_rdata  = aux_rvalid ? mem_rdata : '0;

    // Track consecutive denied aux cycles and remember who owns next cycle's read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= 4'd0;
            rd_owner_p1 <= OWN_NONE;
        end else begin
            if (~aux_req | aux_win)
                starve_cnt <= 4'd0;
            else if (cpu_win)
                starve_cnt <= sat_inc(starve_cnt);

            if (aux_win & ~aux_we)
                rd_owner_p1 <= OWN_AUX;
            else if (cpu_win & ~cpu_we)
                rd_owner_p1 <= OWN_CPU;
            else
                rd_owner_p1 <= OWN_NONE;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural model of the arbitration
// rules and a synthetic memory whose read data is a function of the address.
module tb_dmem_arbiter;

    localparam int DBITS = 32;
    localparam int LIM   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req, cpu_we, aux_req, aux_we;
    logic [DBITS-1:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
    logic             cpu_gnt, cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid;
    logic [DBITS-1:0] cpu_rdata, aux_rdata;
    logic             mem_we;
    logic [DBITS-1:0] mem_addr, mem_wdata;
    logic [DBITS-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: denied-request count of the aux port and pending read.
    int               m_wait = 0;
    int               m_own  = 0;   // 0 none, 1 cpu, 2 aux
    logic [DBITS-1:0] m_raddr = '0;

    dmem_arbiter #(.DBITS(DBITS), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DBITS-1:0] mem_fn(input logic [DBITS-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    // Synthetic DataMemory: read data appears one cycle after the address.
    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

    task automatic chk(input string tag, input logic [DBITS-1:0] got, input logic [DBITS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [DBITS-1:0] ca, input logic [DBITS-1:0] cd,
                         input logic ar, input logic aw, input logic [DBITS-1:0] aa, input logic [DBITS-1:0] ad);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
    endtask

    // One clock cycle: check all outputs mid-cycle, then advance the model at
    // the edge. pat >= 0 additionally checks aux_gnt against a fixed pattern.
    task automatic step(input int pat);
        logic e_aux, e_cpu, e_we, e_crv, e_arv;
        logic [DBITS-1:0] e_addr, e_wd;
        @(negedge clk);
        e_aux  = !reset && aux_req && (!cpu_req || m_wait >= LIM);
        e_cpu  = !reset && cpu_req && !e_aux;
        e_addr = e_aux ? aux_addr : cpu_addr;
        e_wd   = e_aux ? aux_wdata : cpu_wdata;
        e_we   = e_aux ? aux_we : (e_cpu && cpu_we);
        e_crv  = !reset && m_own == 1;
        e_arv  = !reset && m_own == 2;
        chk("aux_gnt",    32'(aux_gnt),    32'(e_aux));
        chk("cpu_gnt",    32'(cpu_gnt),    32'(e_cpu));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !e_cpu));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_addr",   mem_addr,        e_addr);
        chk("mem_wdata",  mem_wdata,       e_wd);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        chk("aux_rvalid", 32'(aux_rvalid), 32'(e_arv));
        chk("cpu_rdata",  cpu_rdata,       e_crv ? mem_fn(m_raddr) : '0);
        chk("aux_rdata",  aux_rdata,       e_arv ? mem_fn(m_raddr) : '0);
        if (pat >= 0) chk("aux_gnt_pattern", 32'(aux_gnt), 32'(pat));
        @(posedge clk);
        if (reset) begin
            m_wait = 0;
            m_own  = 0;
        end else begin
            if (!aux_req || e_aux) m_wait = 0;
            else if (e_cpu && m_wait < LIM) m_wait++;
            m_own   = (e_aux && !aux_we) ? 2 : (e_cpu && !cpu_we) ? 1 : 0;
            m_raddr = e_addr;
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 0, 32'h40, '0, 1, 1, 32'h44, 32'h1);
        step(0); step(0);              // no grants, stall follows cpu_req
        reset = 1'b0;

        // Single CPU read with uncontended grant and 1-cycle return.
        drive(1, 0, 32'h100, '0, 0, 0, '0, '0);
        step(0);
        idle(); step(0);

        // Continuous contention: CPU x4, AUX, CPU x4, AUX, CPU x2.
        drive(1, 0, 32'h200, '0, 1, 0, 32'h300, '0);
        for (int i = 0; i < 12; i++) step((i % 5 == 4) ? 1 : 0);
        idle(); step(0);

        // Interleaved returns: CPU read, then aux read the next cycle.
        drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
        step(0);
        drive(0, 0, '0, '0, 1, 0, 32'h20, '0);
        step(1);
        idle(); step(0);

        // Aux-only write to the LEDR register.
        drive(0, 0, '0, '0, 1, 1, 32'hF000_0004, 32'h3FF);
        step(1);
        idle(); step(0);

        // Reset lands while a CPU read is in flight.
        drive(1, 0, 32'h80, '0, 0, 0, '0, '0);
        step(0);
        reset = 1'b1;
        drive(1, 0, 32'h84, '0, 1, 0, 32'h88, '0);
        step(0);
        reset = 1'b0;
        drive(1, 0, 32'h84, '0, 0, 0, '0, '0);
        step(0);
        idle(); step(0);

        // Aux drops its request after two contended cycles: counter restarts.
        drive(1, 0, 32'h400, '0, 1, 0, 32'h500, '0);
        step(0); step(0);
        aux_req = 1'b0;
        step(0); step(0);
        aux_req = 1'b1;
        for (int i = 0; i < 5; i++) step((i == 4) ? 1 : 0);
        idle(); step(0);

        // Randomized traffic; aux usually holds its request until granted.
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_we  = $urandom_range(0, 1) == 1;
            cpu_addr  = $urandom & 32'hFFFF_FFFC;
            cpu_wdata = $urandom;
            if (!(aux_req && $urandom_range(0, 9) != 0)) begin
                aux_req   = ($urandom_range(0, 2) == 0);
                aux_we    = $urandom_range(0, 1) == 1;
                aux_addr  = $urandom & 32'hFFFF_FFFC;
                aux_wdata = $urandom;
            end
            step(-1);
            if (aux_gnt) aux_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
